// File: rtl/font_glyph_blitter_if.sv
// font_glyph_blitter_if
// Bundles the blit command/handshake and the SRAM write channel of the glyph
// blitter into one interface.
//   master : the blitter itself. It receives start/glyph/fg/bg/attr/base_addr
//            and mem_done, and drives ready/done and the SRAM request
//            (mem_req, mem_addr, mem_dout).
//   slave  : the surroundings of the blitter (text-grid scanner plus SRAM
//            arbiter), with the directions reversed.
// Parameters must match those of the font_glyph_blitter instance it feeds.
interface font_glyph_blitter_if #(
    parameter int CHAR_W  = 8,
    parameter int CHAR_H  = 16,
    parameter int COLOR_W = 24,
    parameter int ADDR_W  = 20
);
    logic                       start;
    logic                       ready;
    logic [CHAR_W*CHAR_H-1:0]   glyph;
    logic [COLOR_W-1:0]         fg;
    logic [COLOR_W-1:0]         bg;
    logic [2:0]                 attr;
    logic [ADDR_W-1:0]          base_addr;
    logic                       mem_req;
    logic [ADDR_W-1:0]          mem_addr;
    logic [COLOR_W-1:0]         mem_dout;
    logic                       mem_done;
    logic                       done;

    modport master (
        input  start, glyph, fg, bg, attr, base_addr, mem_done,
        output ready, mem_req, mem_addr, mem_dout, done
    );

    modport slave (
        output start, glyph, fg, bg, attr, base_addr, mem_done,
        input  ready, mem_req, mem_addr, mem_dout, done
    );
endinterface

// File: rtl/font_glyph_blitter.sv
// font_glyph_blitter
// Expands one CHAR_W x CHAR_H glyph bitmap into a linear framebuffer, one
// SRAM word write per pixel, with inverse and underline attributes.
//   clk  : system clock
//   rst  : asynchronous, active-high reset (abandons any write in flight)
//   bus  : font_glyph_blitter_if.master
//          start/ready       command handshake (accepted only while ready=1)
//          glyph/fg/bg/attr  bitmap (bit y*CHAR_W+x is pixel (x,y)), colours,
//                            attr[0]=inverse, attr[1]=underline,
//                            attr[2]=transparent
//          base_addr         word address of the glyph's top-left pixel
//          mem_req/mem_addr/mem_dout/mem_done  SRAM write channel
//          done              one-cycle pulse after the last pixel
// Optional feature: define FONT_GLYPH_BLITTER_TRANSPARENT_EN to make
// attr[2] skip background pixels (no SRAM write, one SKIP cycle each).
// Without it attr[2] is ignored and every pixel is written.
module font_glyph_blitter #(
    parameter int CHAR_W  = 8,
    parameter int CHAR_H  = 16,
    parameter int COLOR_W = 24,
    parameter int ADDR_W  = 20,
    parameter int STRIDE  = 640
) (
    input  logic                    clk,
    input  logic                    rst,
    font_glyph_blitter_if.master    bus
);
    localparam int GLYPH_W = CHAR_W * CHAR_H;
    localparam int XW      = $clog2(CHAR_W);
    localparam int YW      = $clog2(CHAR_H);
    localparam logic [XW-1:0]     X_LAST   = XW'(CHAR_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(CHAR_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
`ifdef FONT_GLYPH_BLITTER_TRANSPARENT_EN
        ST_SKIP   = 2'd2,
`endif
        ST_FINISH = 2'd3
    } state_t;

    state_t                 state_r;
    logic [XW-1:0]          x_r;
    logic [YW-1:0]          y_r;
    // Address of pixel (0,y): base + y*STRIDE, kept incrementally so that no
    // multiplier is needed; wraps naturally at ADDR_W bits.
    logic [ADDR_W-1:0]      row_base_r;
    logic [GLYPH_W-1:0]     glyph_r;
    logic [COLOR_W-1:0]     fg_r;
    logic [COLOR_W-1:0]     bg_r;
    logic [2:0]             attr_r;
    logic                   ready_r;
    logic                   mem_req_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [COLOR_W-1:0]     mem_dout_r;
    logic                   done_r;

    logic [GLYPH_W-1:0]     src_glyph_s;
    logic [2:0]             src_attr_s;
    logic [COLOR_W-1:0]     src_fg_s;
    logic [COLOR_W-1:0]     src_bg_s;
    logic [XW-1:0]          cand_x_s;
    logic [YW-1:0]          cand_y_s;
    logic [ADDR_W-1:0]      cand_row_s;
    logic [ADDR_W-1:0]      cand_addr_s;
    logic [COLOR_W-1:0]     cand_data_s;
    logic                   adv_last_s;
    logic                   adv_go_s;
    logic                   pix_s;
    logic                   load_req_s;
    state_t                 load_state_s;

    // Final pixel value: bitmap bit, forced on in the underline row, then
    // optionally inverted.
    function automatic logic pixel_on(
        input logic [GLYPH_W-1:0] g,
        input logic [1:0]         a,
        input logic [XW-1:0]      px,
        input logic [YW-1:0]      py
    );
        int   idx;
        logic p;
        idx = int'(py) * CHAR_W + int'(px);
        p   = (a[1] && (py == Y_LAST)) ? 1'b1 : g[idx];
        return a[0] ? ~p : p;
    endfunction

    // Next pixel to present: (0,0) of the incoming command while idle,
    // otherwise the raster successor of the current pixel.
    always_comb begin
        src_glyph_s = glyph_r;
        src_attr_s  = attr_r;
        src_fg_s    = fg_r;
        src_bg_s    = bg_r;
        cand_x_s    = '0;
        cand_y_s    = '0;
        cand_row_s  = row_base_r;
        adv_last_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            // Accept cycle: the latched copy is not loaded yet, use the inputs.
            src_glyph_s = bus.glyph;
            src_attr_s  = bus.attr;
            src_fg_s    = bus.fg;
            src_bg_s    = bus.bg;
            cand_row_s  = bus.base_addr;
        end else if (x_r != X_LAST) begin
            cand_x_s = x_r + 1'b1;
            cand_y_s = y_r;
        end else if (y_r != Y_LAST) begin
            cand_y_s   = y_r + 1'b1;
            cand_row_s = row_base_r + STRIDE_A;
        end else begin
            cand_y_s   = y_r;
            adv_last_s = 1'b1;
        end
        pix_s       = pixel_on(src_glyph_s, src_attr_s[1:0], cand_x_s, cand_y_s);
        cand_addr_s = cand_row_s + ADDR_W'(cand_x_s);
        cand_data_s = pix_s ? src_fg_s : src_bg_s;
`ifdef FONT_GLYPH_BLITTER_TRANSPARENT_EN
        // Transparent background pixels get a SKIP cycle instead of a write.
        load_req_s   = ~(src_attr_s[2] & ~pix_s);
        load_state_s = load_req_s ? ST_WRITE : ST_SKIP;
        adv_go_s     = ((state_r == ST_WRITE) && bus.mem_done) || (state_r == ST_SKIP);
`else
        load_req_s   = 1'b1;
        load_state_s = ST_WRITE;
        adv_go_s     = (state_r == ST_WRITE) && bus.mem_done;
`endif
    end

`ifndef FONT_GLYPH_BLITTER_TRANSPARENT_EN
    // attr[2] has no effect in this build.
    logic unused_attr_s;
    assign unused_attr_s = src_attr_s[2];
`endif

    // Blit sequencer: command latch, raster counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            x_r        <= '0;
            y_r        <= '0;
            row_base_r <= '0;
            glyph_r    <= '0;
            fg_r       <= '0;
            bg_r       <= '0;
            attr_r     <= 3'b000;
            ready_r    <= 1'b1;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            mem_dout_r <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        glyph_r    <= bus.glyph;
                        fg_r       <= bus.fg;
                        bg_r       <= bus.bg;
                        attr_r     <= bus.attr;
                        x_r        <= cand_x_s;
                        y_r        <= cand_y_s;
                        row_base_r <= cand_row_s;
                        mem_addr_r <= cand_addr_s;
                        mem_dout_r <= cand_data_s;
                        mem_req_r  <= load_req_s;
                        state_r    <= load_state_s;
                        ready_r    <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifdef FONT_GLYPH_BLITTER_TRANSPARENT_EN
                ST_WRITE, ST_SKIP: begin
`else
                ST_WRITE: begin
`endif
                    if (adv_go_s) begin
                        if (adv_last_s) begin
                            mem_req_r <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= ST_FINISH;
                        end else begin
                            x_r        <= cand_x_s;
                            y_r        <= cand_y_s;
                            row_base_r <= cand_row_s;
                            mem_addr_r <= cand_addr_s;
                            mem_dout_r <= cand_data_s;
                            mem_req_r  <= load_req_s;
                            state_r    <= load_state_s;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FINISH: begin
                    // done is high for this one cycle; start is not looked at.
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_dout = mem_dout_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_font_glyph_blitter.sv
// tb_font_glyph_blitter
// Directed bench for font_glyph_blitter: a default-sized instance and a
// second instance with a 14-bit address bus for the wrap-around case.
module tb_font_glyph_blitter;
    localparam int CW   = 8;
    localparam int CH   = 16;
    localparam int COLW = 24;
    localparam int AW   = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    font_glyph_blitter_if #(.CHAR_W(CW), .CHAR_H(CH), .COLOR_W(COLW), .ADDR_W(AW)) bus ();
    font_glyph_blitter_if #(.CHAR_W(CW), .CHAR_H(CH), .COLOR_W(COLW), .ADDR_W(14)) bus14 ();

    font_glyph_blitter #(.CHAR_W(CW), .CHAR_H(CH), .COLOR_W(COLW), .ADDR_W(AW), .STRIDE(640))
        u_dut (.clk(clk), .rst(rst), .bus(bus.master));
    font_glyph_blitter #(.CHAR_W(CW), .CHAR_H(CH), .COLOR_W(COLW), .ADDR_W(14), .STRIDE(640))
        u_dut14 (.clk(clk), .rst(rst), .bus(bus14.master));

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0]   wr_addr[$];
    logic [COLW-1:0] wr_data[$];
    int  done_at;
    int  stable_err;
    logic first_req, first_ready, fin_req, fin_ready, fin_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One blit on u_dut. mem_done is high on cycles where c%period==period-1
    // (c counts cycles after the accept edge). Inputs are scrambled after the
    // accept cycle; poke raises start at c==10 while busy; start is also raised
    // in the FINISH cycle.
    task automatic run_blit(input logic [127:0] g, input logic [23:0] f, input logic [23:0] b,
                            input logic [2:0] a, input logic [19:0] base,
                            input int period, input bit poke);
        logic [AW-1:0]   pa;
        logic [COLW-1:0] pd;
        logic            hold;
        wr_addr.delete();
        wr_data.delete();
        done_at    = -1;
        stable_err = 0;
        hold       = 1'b0;
        pa         = '0;
        pd         = '0;
        @(negedge clk);
        bus.glyph = g; bus.fg = f; bus.bg = b; bus.attr = a; bus.base_addr = base;
        bus.start = 1'b1; bus.mem_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.glyph = ~g; bus.fg = b; bus.bg = f; bus.attr = ~a; bus.base_addr = base + 20'h00123;
        first_req   = bus.mem_req;
        first_ready = bus.ready;
        for (int c = 0; c < 2000; c++) begin
            if (bus.done === 1'b1) begin
                done_at = c;
                break;
            end
            if (hold && (bus.mem_addr !== pa || bus.mem_dout !== pd)) stable_err++;
            bus.mem_done = ((c % period) == (period - 1));
            bus.start    = poke && (c == 10);
            if (bus.mem_req === 1'b1 && bus.mem_done) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_dout);
            end
            hold = bus.mem_req && !bus.mem_done;
            pa   = bus.mem_addr;
            pd   = bus.mem_dout;
            @(negedge clk);
        end
        bus.start = 1'b1;
        @(negedge clk);
        fin_req   = bus.mem_req;
        fin_ready = bus.ready;
        fin_done  = bus.done;
        bus.start = 1'b0;
        bus.mem_done = 1'b0;
    endtask

    // Compare recorded writes against a raster walk of the glyph.
    task automatic verify_blit(input string tag, input logic [127:0] g, input logic [23:0] f,
                               input logic [23:0] b, input logic [2:0] a, input logic [19:0] base);
        int n_exp = 0;
        int bad   = 0;
        for (int y = 0; y < CH; y++) begin
            for (int x = 0; x < CW; x++) begin
                logic p;
                logic [AW-1:0] ea;
                p = g[y*CW + x];
                if (a[1] && y == CH - 1) p = 1'b1;
                if (a[0]) p = ~p;
`ifdef FONT_GLYPH_BLITTER_TRANSPARENT_EN
                if (a[2] && !p) continue;
`endif
                ea = base + 20'(y*640 + x);
                if (n_exp >= wr_addr.size()) bad++;
                else if (wr_addr[n_exp] !== ea || wr_data[n_exp] !== (p ? f : b)) bad++;
                n_exp++;
            end
        end
        check({tag, "_count"}, 64'(wr_addr.size()), 64'(n_exp));
        check({tag, "_content"}, 64'(bad), 64'd0);
        check({tag, "_done_seen"}, 64'(done_at >= 0), 64'd1);
        check({tag, "_fin_req"}, 64'(fin_req), 64'd0);
        check({tag, "_fin_ready"}, 64'(fin_ready), 64'd1);
        check({tag, "_fin_done"}, 64'(fin_done), 64'd0);
    endtask

    initial begin
        int dcount;
        logic [127:0] g10;
        rst = 1'b1;
        bus.start = 1'b0; bus.glyph = '0; bus.fg = '0; bus.bg = '0; bus.attr = 3'b000;
        bus.base_addr = '0; bus.mem_done = 1'b0;
        bus14.start = 1'b0; bus14.glyph = '0; bus14.fg = '0; bus14.bg = '0; bus14.attr = 3'b000;
        bus14.base_addr = '0; bus14.mem_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Blank glyph, mem_done tied high: 128 background writes,
        // done on the 130th cycle counting the start cycle as the first.
        run_blit(128'h0, 24'hFFFFFF, 24'h000000, 3'b000, 20'd0, 1, 1'b0);
        check("t1_first_req", 64'(first_req), 64'd1);
        check("t1_first_ready", 64'(first_ready), 64'd0);
        check("t1_done_at", 64'(done_at), 64'd128);
        check("t1_addr8", 64'(wr_addr[8]), 64'd640);
        check("t1_addr127", 64'(wr_addr[127]), 64'd9607);
        verify_blit("t1", 128'h0, 24'hFFFFFF, 24'h000000, 3'b000, 20'd0);

        // Inverse with only bit 0 set
        run_blit(128'h1, 24'hA5A5A5, 24'h5A5A5A, 3'b001, 20'd100, 1, 1'b0);
        check("t2_addr0", 64'(wr_addr[0]), 64'd100);
        check("t2_data0", 64'(wr_data[0]), 64'h5A5A5A);
        check("t2_data1", 64'(wr_data[1]), 64'hA5A5A5);
        check("t2_addr127", 64'(wr_addr[127]), 64'd9707);
        verify_blit("t2", 128'h1, 24'hA5A5A5, 24'h5A5A5A, 3'b001, 20'd100);

        // Underline
        run_blit(128'h0, 24'h112233, 24'h445566, 3'b010, 20'd7, 1, 1'b0);
        check("t3_data119", 64'(wr_data[119]), 64'h445566);
        check("t3_data120", 64'(wr_data[120]), 64'h112233);
        check("t3_addr120", 64'(wr_addr[120]), 64'd9607);
        verify_blit("t3", 128'h0, 24'h112233, 24'h445566, 3'b010, 20'd7);

        // Underline plus inverse
        run_blit(128'h0, 24'h112233, 24'h445566, 3'b011, 20'd7, 1, 1'b0);
        check("t4_data0", 64'(wr_data[0]), 64'h112233);
        check("t4_data120", 64'(wr_data[120]), 64'h445566);
        verify_blit("t4", 128'h0, 24'h112233, 24'h445566, 3'b011, 20'd7);

        // mem_done every 3rd cycle, start poked mid-blit
        run_blit(128'hF0F0_0000_1234_5678_9ABC_DEF0_0F0F_AAAA, 24'h00FF00, 24'h0000FF,
                 3'b000, 20'd2000, 3, 1'b1);
        check("t5_done_at", 64'(done_at), 64'd384);
        check("t5_stable", 64'(stable_err), 64'd0);
        verify_blit("t5", 128'hF0F0_0000_1234_5678_9ABC_DEF0_0F0F_AAAA, 24'h00FF00, 24'h0000FF,
                    3'b000, 20'd2000);

        // Transparent attribute with a 10-pixel glyph
        g10 = 128'h8000_0000_0000_0001_0000_00F0_0000_0107;
        run_blit(g10, 24'hCAFE01, 24'h0BEEF0, 3'b100, 20'd500, 1, 1'b0);
`ifdef FONT_GLYPH_BLITTER_TRANSPARENT_EN
        check("t6_writes", 64'(wr_addr.size()), 64'd10);
        check("t6_last_addr", 64'(wr_addr[9]), 64'd10107);
`else
        check("t6_writes", 64'(wr_addr.size()), 64'd128);
        check("t6_last_addr", 64'(wr_addr[127]), 64'd10107);
`endif
        check("t6_data0", 64'(wr_data[0]), 64'hCAFE01);
        verify_blit("t6", g10, 24'hCAFE01, 24'h0BEEF0, 3'b100, 20'd500);

        // 14-bit address wrap, then asynchronous reset mid-row
        @(negedge clk);
        bus14.glyph = '0; bus14.fg = 24'h123456; bus14.bg = 24'h654321; bus14.attr = 3'b000;
        bus14.base_addr = 14'h3FFF; bus14.mem_done = 1'b1; bus14.start = 1'b1;
        @(negedge clk);
        bus14.start = 1'b0;
        check("w_addr0", 64'(bus14.mem_addr), 64'h3FFF);
        check("w_data0", 64'(bus14.mem_dout), 64'h654321);
        @(negedge clk);
        check("w_addr1", 64'(bus14.mem_addr), 64'h0000);
        repeat (3) @(negedge clk);
        check("w_req_before_rst", 64'(bus14.mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("w_rst_req", 64'(bus14.mem_req), 64'd0);
        check("w_rst_ready", 64'(bus14.ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus14.done === 1'b1 || bus14.mem_req === 1'b1) dcount++;
        end
        check("w_no_done_after_rst", 64'(dcount), 64'd0);
        check("w_ready_after_rst", 64'(bus14.ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
